valid_pattern_generator: RTL and testbench

VALID_PATTERN_GENERATOR -- requirements
Module: valid_pattern_generator

---
 rtl/valid_pattern_generator_if.sv | 36 +++
 rtl/valid_pattern_generator.sv | 152 +++++++++++++++
 tb/tb_valid_pattern_generator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/valid_pattern_generator_if.sv
// valid_pattern_generator_if
// Purpose : bundles the request/qualifier inputs and the valid-lane outputs
//           of the VALTRAIN pattern generator into one connection.
// Signals : i_enable_128    - request a fixed-length VALTRAIN burst
//           i_enable_cons   - request continuous VALTRAIN
//           i_tx_data_valid - functional-mode valid qualifier
//           i_inject_error  - per-cycle error injection strobe
//           i_error_mask    - XOR mask used when injecting
//           o_tvld_l        - registered transmit valid-lane word
//           o_pattern_active- high while a VALTRAIN word is on o_tvld_l
//           o_done          - one-cycle burst completion pulse
//           o_iter_count    - 8-bit iterations sent in the current burst
// Modports: master drives the i_* side, slave is the generator.
interface valid_pattern_generator_if;
    logic        i_enable_128;
    logic        i_enable_cons;
    logic        i_tx_data_valid;
    logic        i_inject_error;
    logic [31:0] i_error_mask;
    logic [31:0] o_tvld_l;
    logic        o_pattern_active;
    logic        o_done;
    logic [7:0]  o_iter_count;

    modport master (
        output i_enable_128, i_enable_cons, i_tx_data_valid,
               i_inject_error, i_error_mask,
        input  o_tvld_l, o_pattern_active, o_done, o_iter_count
    );

    modport slave (
        input  i_enable_128, i_enable_cons, i_tx_data_valid,
               i_inject_error, i_error_mask,
        output o_tvld_l, o_pattern_active, o_done, o_iter_count
    );
endinterface

// File: rtl/valid_pattern_generator.sv
// valid_pattern_generator
// Purpose : drives the transmit valid lane either with the functional valid
//           qualifier or with the VALTRAIN training word (8'b11110000 x4),
//           as a fixed burst of WORDS_128 words or continuously.
// Ports   : i_clk   - system clock, rising edge
//           i_rst_n - asynchronous active-low reset
//           bus     - valid_pattern_generator_if.slave (requests, error
//                     injection, valid-lane word and status)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | functional output: all-ones when i_tx_data_valid, else zero
// ITER  | fixed burst, one VALTRAIN word per cycle, counted
// CONS  | continuous VALTRAIN while i_enable_cons is held
// DONE  | burst finished, output zero until i_enable_128 drops
module valid_pattern_generator #(
    parameter int WORDS_128 = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    valid_pattern_generator_if.slave    bus
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_ITER = 2'd1;
    localparam logic [1:0]  S_CONS = 2'd2;
    localparam logic [1:0]  S_DONE = 2'd3;

    localparam logic [31:0] VALTRAIN  = 32'hF0F0_F0F0;
    localparam logic [5:0]  LAST_WORD = 6'(WORDS_128);

    logic [1:0]  r_state;
    logic [5:0]  r_word_cnt;
    logic [7:0]  r_iter_count;
    logic [31:0] r_tvld_l;
    logic        r_pattern_active;
    logic        r_done;

    logic [1:0]  w_state_nxt;
    logic [5:0]  w_word_cnt_nxt;
    logic [7:0]  w_iter_nxt;
    logic [31:0] w_tvld_nxt;
    logic        w_active_nxt;
    logic        w_done_nxt;

    logic [31:0] w_word;
    logic [31:0] w_func;
    logic [8:0]  w_iter_sum;
    logic [7:0]  w_iter_sat;

    // Injection only reaches the lane through w_word, so IDLE/DONE
    // outputs are naturally unaffected by the strobe.
    assign w_word     = VALTRAIN ^ (bus.i_inject_error ? bus.i_error_mask : 32'h0);
    assign w_func     = bus.i_tx_data_valid ? 32'hFFFF_FFFF : 32'h0000_0000;
    assign w_iter_sum = {1'b0, r_iter_count} + 9'd4;
    assign w_iter_sat = w_iter_sum[8] ? 8'hFF : w_iter_sum[7:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_iter_nxt     = r_iter_count;
        w_tvld_nxt     = 32'h0;
        w_active_nxt   = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_word_cnt_nxt = 6'd0;
                w_iter_nxt     = 8'd0;
                w_tvld_nxt     = w_func;
                // The first pattern word goes out on the entry edge.
                if (bus.i_enable_128 && !bus.i_enable_cons) begin
                    w_state_nxt    = S_ITER;
                    w_word_cnt_nxt = 6'd1;
                    w_iter_nxt     = 8'd4;
                    w_tvld_nxt     = w_word;
                    w_active_nxt   = 1'b1;
                end else if (bus.i_enable_cons && !bus.i_enable_128) begin
                    w_state_nxt    = S_CONS;
                    w_iter_nxt     = 8'd4;
                    w_tvld_nxt     = w_word;
                    w_active_nxt   = 1'b1;
                end
            end
            S_ITER: begin
                // An abort takes priority over completion on the same edge.
                if (!bus.i_enable_128) begin
                    w_state_nxt    = S_IDLE;
                    w_word_cnt_nxt = 6'd0;
                    w_iter_nxt     = 8'd0;
                    w_tvld_nxt     = w_func;
                end else if (r_word_cnt == LAST_WORD) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_word_cnt_nxt = r_word_cnt + 6'd1;
                    w_iter_nxt     = w_iter_sat;
                    w_tvld_nxt     = w_word;
                    w_active_nxt   = 1'b1;
                end
            end
            S_CONS: begin
                if (bus.i_enable_cons) begin
                    w_iter_nxt   = w_iter_sat;
                    w_tvld_nxt   = w_word;
                    w_active_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_iter_nxt  = 8'd0;
                    w_tvld_nxt  = w_func;
                end
            end
            S_DONE: begin
                // Holding the enable keeps us here so it cannot retrigger.
                if (!bus.i_enable_128) begin
                    w_state_nxt    = S_IDLE;
                    w_word_cnt_nxt = 6'd0;
                    w_iter_nxt     = 8'd0;
                    w_tvld_nxt     = w_func;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_word_cnt_nxt = 6'd0;
                w_iter_nxt     = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_word_cnt       <= 6'd0;
            r_iter_count     <= 8'd0;
            r_tvld_l         <= 32'h0;
            r_pattern_active <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_word_cnt       <= w_word_cnt_nxt;
            r_iter_count     <= w_iter_nxt;
            r_tvld_l         <= w_tvld_nxt;
            r_pattern_active <= w_active_nxt;
            r_done           <= w_done_nxt;
        end
    end

    assign bus.o_tvld_l         = r_tvld_l;
    assign bus.o_pattern_active = r_pattern_active;
    assign bus.o_done           = r_done;
    assign bus.o_iter_count     = r_iter_count;

endmodule

// File: tb/tb_valid_pattern_generator.sv
// tb_valid_pattern_generator
// Purpose : self-checking bench for valid_pattern_generator; single-cycle
//           behaviour from a vector table, multi-cycle bursts by hand.
module tb_valid_pattern_generator;

    localparam logic [31:0] PAT = 32'hF0F0_F0F0;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    valid_pattern_generator_if vif ();

    valid_pattern_generator #(.WORDS_128(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en128;
        logic        cons;
        logic        valid;
        logic        inj;
        logic [31:0] mask;
        logic [31:0] tvld;
        logic        act;
        logic        done;
        logic [7:0]  iter;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en128, input logic cons, input logic valid,
                         input logic inj, input logic [31:0] mask);
        vif.i_enable_128    = en128;
        vif.i_enable_cons   = cons;
        vif.i_tx_data_valid = valid;
        vif.i_inject_error  = inj;
        vif.i_error_mask    = mask;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] tvld, input logic act,
                           input logic done, input logic [7:0] iter);
        chk($sformatf("%s tvld", tag), vif.o_tvld_l, tvld);
        chk($sformatf("%s active", tag), {31'h0, vif.o_pattern_active}, {31'h0, act});
        chk($sformatf("%s done", tag), {31'h0, vif.o_done}, {31'h0, done});
        chk($sformatf("%s iter", tag), {24'h0, vif.o_iter_count}, {24'h0, iter});
    endtask

    initial begin
        int words;
        int dones;
        int errs;
        logic [7:0] exp_iter;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        //              en cons val inj mask           tvld           act done iter
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1,        32'h0000_0000, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF,     32'hFFFF_FFFF, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'hF0F0_F0F0, 1'b1, 1'b0, 8'd4};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1, 1'b0, 8'd8};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'hF0F0_F0F0, 1'b1, 1'b0, 8'd4};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h70F0_F0F0, 1'b1, 1'b0, 8'd8};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b0, 8'd0};

        repeat (3) tick();
        chk_all("reset", 32'h0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].en128, vecs[i].cons, vecs[i].valid, vecs[i].inj, vecs[i].mask);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].tvld, vecs[i].act, vecs[i].done, vecs[i].iter);
        end

        // 40-cycle burst request: 32 words, one done pulse, then zero while held
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        words = 0;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (vif.o_pattern_active && vif.o_tvld_l == PAT) words++;
            if (vif.o_done) dones++;
            if (k <= 32)
                chk_all($sformatf("burst k%0d", k), PAT, 1'b1, 1'b0, 8'(4 * k));
            else if (k == 33)
                chk_all("burst done", 32'h0, 1'b0, 1'b1, 8'd128);
            else
                chk_all($sformatf("burst hold k%0d", k), 32'h0, 1'b0, 1'b0, 8'd128);
        end
        chk("burst words", words, 32);
        chk("burst dones", dones, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_all("burst idle", 32'h0, 1'b0, 1'b0, 8'd0);

        // continuous mode for 70 cycles with saturating iteration count
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 70; k++) begin
            tick();
            exp_iter = (4 * k > 255) ? 8'hFF : 8'(4 * k);
            chk_all($sformatf("cons k%0d", k), PAT, 1'b1, 1'b0, exp_iter);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_all("cons exit", 32'h0, 1'b0, 1'b0, 8'd0);

        // abort after 10 words
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        dones = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (vif.o_done) dones++;
        end
        chk("abort iter before drop", {24'h0, vif.o_iter_count}, 32'd40);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        if (vif.o_done) dones++;
        chk_all("abort", 32'h0, 1'b0, 1'b0, 8'd0);
        tick();
        if (vif.o_done) dones++;
        chk("abort dones", dones, 0);

        // single injected error on word 5
        words = 0;
        errs  = 0;
        for (int k = 1; k <= 40; k++) begin
            drive(1'b1, 1'b0, 1'b0, (k == 5), 32'h0000_0001);
            tick();
            if (vif.o_pattern_active) begin
                words++;
                if (vif.o_tvld_l != PAT) errs++;
            end
            if (k == 5) chk("inject word5", vif.o_tvld_l, 32'hF0F0_F0F1);
            if (k == 6) chk("inject word6", vif.o_tvld_l, PAT);
        end
        chk("inject words", words, 32);
        chk("inject errs", errs, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // asynchronous reset at word 20, then a fresh burst
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (20) tick();
        chk("pre-reset iter", {24'h0, vif.o_iter_count}, 32'd80);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 32'h0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_all("reset held", 32'h0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        words = 0;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (vif.o_pattern_active && vif.o_tvld_l == PAT) words++;
            if (vif.o_done) dones++;
            if (k == 1) chk_all("restart first", PAT, 1'b1, 1'b0, 8'd4);
            if (k == 33) chk_all("restart done", 32'h0, 1'b0, 1'b1, 8'd128);
        end
        chk("restart words", words, 32);
        chk("restart dones", dones, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_all("final idle", 32'h0, 1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
